// File: rtl/cpu_bus_pkg.sv
// Shared types and helpers for the CPU-side bus controller.
package cpu_bus_pkg;

   localparam int unsigned MAX_ADDR_W = 32;

   // FSM encoding
   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] ACCESS = 1'b1;

   // Index width for a channel count; a single channel still needs one bit.
   function automatic int unsigned sel_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic ch_hit(input logic [MAX_ADDR_W-1:0] addr,
                                   input logic [MAX_ADDR_W-1:0] base,
                                   input logic [MAX_ADDR_W-1:0] mask);
      return (addr & mask) == (base & mask);
   endfunction

endpackage

// File: rtl/cpu_bus_if.sv
// CPU-side handshake: request from the core, data/ready/error back to it.
interface cpu_bus_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 8
) ();
   logic              syn_clk;
   logic [ADDR_W-1:0] addr_out;
   logic [DATA_W-1:0] data_out;
   logic              ren;
   logic              wen;
   logic [DATA_W-1:0] data_in;
   logic              rdy;
   logic              bus_err;

   modport master (output syn_clk, addr_out, data_out, ren, wen,
                   input  data_in, rdy, bus_err);
   modport slave  (input  syn_clk, addr_out, data_out, ren, wen,
                   output data_in, rdy, bus_err);
endinterface

// File: rtl/cpu_addr_decoder.sv
// Priority address decoder: lowest-index matching channel wins.
module cpu_addr_decoder
   import cpu_bus_pkg::*;
#(
   parameter int unsigned               NUM_CH  = 4,
   parameter int unsigned               ADDR_W  = 16,
   parameter logic [NUM_CH*ADDR_W-1:0]  CH_BASE = '0,
   parameter logic [NUM_CH*ADDR_W-1:0]  CH_MASK = '0
) (
   input  logic [ADDR_W-1:0]         addr,
   output logic                      hit,
   output logic [sel_w(NUM_CH)-1:0]  sel
);
   localparam int unsigned SEL_W = sel_w(NUM_CH);

   // Scan downward so the lowest matching index is the last one written.
   always_comb begin
      hit = 1'b0;
      sel = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (ch_hit(MAX_ADDR_W'(addr),
                    MAX_ADDR_W'(CH_BASE[i*ADDR_W +: ADDR_W]),
                    MAX_ADDR_W'(CH_MASK[i*ADDR_W +: ADDR_W]))) begin
            hit = 1'b1;
            sel = SEL_W'(i);
         end
      end
   end
endmodule

// File: rtl/cpu_bus_ctrl.sv
// CPU bus controller: decodes, strobes one channel, stretches rdy for wait
// states / target ack, and keeps an open-bus value on data_in.
module cpu_bus_ctrl
   import cpu_bus_pkg::*;
#(
   parameter int unsigned               NUM_CH  = 4,
   parameter int unsigned               ADDR_W  = 16,
   parameter int unsigned               DATA_W  = 8,
   parameter int unsigned               WAIT_W  = 3,
   parameter logic [NUM_CH*ADDR_W-1:0]  CH_BASE = '0,
   parameter logic [NUM_CH*ADDR_W-1:0]  CH_MASK = '0,
   parameter logic [NUM_CH*WAIT_W-1:0]  CH_WAIT = '0,
   parameter logic [NUM_CH-1:0]         CH_ACK  = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   cpu_bus_if.slave                 cpu,
   output logic [ADDR_W-1:0]        ch_addr,
   output logic [DATA_W-1:0]        ch_wdata,
   output logic [NUM_CH-1:0]        ch_ren,
   output logic [NUM_CH-1:0]        ch_wen,
   input  logic [NUM_CH*DATA_W-1:0] ch_rdata,
   input  logic [NUM_CH-1:0]        ch_ack
);
   localparam int unsigned SEL_W = sel_w(NUM_CH);

   logic [0:0]        state_q, state_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [WAIT_W-1:0] cnt_q, cnt_d;
   logic              is_wr_q, is_wr_d;
   logic [ADDR_W-1:0] ch_addr_q, ch_addr_d;
   logic [DATA_W-1:0] ch_wdata_q, ch_wdata_d;
   logic [NUM_CH-1:0] ch_ren_q, ch_ren_d, ch_wen_q, ch_wen_d;
   logic [DATA_W-1:0] data_in_q, data_in_d;
   logic              bus_err_q, bus_err_d;

   logic              dec_hit;
   logic [SEL_W-1:0]  dec_sel;
   logic [WAIT_W-1:0] wait_dec;
   logic [DATA_W-1:0] rdata_sel;
   logic              ack_sel, ack_req_sel;
   logic              done_c;

   cpu_addr_decoder #(
      .NUM_CH  (NUM_CH),
      .ADDR_W  (ADDR_W),
      .CH_BASE (CH_BASE),
      .CH_MASK (CH_MASK)
   ) u_dec (
      .addr (cpu.addr_out),
      .hit  (dec_hit),
      .sel  (dec_sel)
   );

   // Per-channel muxes: wait count for the decoded channel, data/ack for the latched one.
   always_comb begin
      wait_dec    = '0;
      rdata_sel   = '0;
      ack_sel     = 1'b0;
      ack_req_sel = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (SEL_W'(i) == dec_sel) wait_dec = CH_WAIT[i*WAIT_W +: WAIT_W];
         if (SEL_W'(i) == sel_q) begin
            rdata_sel   = ch_rdata[i*DATA_W +: DATA_W];
            ack_sel     = ch_ack[i];
            ack_req_sel = CH_ACK[i];
         end
      end
   end

   assign done_c  = (state_q == ACCESS) && (cnt_q == '0) && (!ack_req_sel || ack_sel);
   assign cpu.rdy = (state_q == IDLE) || done_c;

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      cnt_d      = cnt_q;
      is_wr_d    = is_wr_q;
      ch_addr_d  = ch_addr_q;
      ch_wdata_d = ch_wdata_q;
      ch_ren_d   = ch_ren_q;
      ch_wen_d   = ch_wen_q;
      data_in_d  = data_in_q;
      bus_err_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (cpu.syn_clk && (cpu.ren || cpu.wen)) begin
               bus_err_d = cpu.ren && cpu.wen;
               if (dec_hit) begin
                  state_d    = ACCESS;
                  sel_d      = dec_sel;
                  cnt_d      = wait_dec;
                  is_wr_d    = cpu.wen;
                  ch_addr_d  = cpu.addr_out;
                  ch_wdata_d = cpu.data_out;
                  if (cpu.wen) ch_wen_d = NUM_CH'(1) << dec_sel;
                  else         ch_ren_d = NUM_CH'(1) << dec_sel;
               end else if (cpu.wen) begin
                  data_in_d = cpu.data_out;
               end
            end
         end
         default: begin
            if (cnt_q != '0) cnt_d = cnt_q - WAIT_W'(1);
            if (done_c) begin
               data_in_d = is_wr_q ? ch_wdata_q : rdata_sel;
               state_d   = IDLE;
               ch_ren_d  = '0;
               ch_wen_d  = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         sel_q      <= '0;
         cnt_q      <= '0;
         is_wr_q    <= 1'b0;
         ch_addr_q  <= '0;
         ch_wdata_q <= '0;
         ch_ren_q   <= '0;
         ch_wen_q   <= '0;
         data_in_q  <= '0;
         bus_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         cnt_q      <= cnt_d;
         is_wr_q    <= is_wr_d;
         ch_addr_q  <= ch_addr_d;
         ch_wdata_q <= ch_wdata_d;
         ch_ren_q   <= ch_ren_d;
         ch_wen_q   <= ch_wen_d;
         data_in_q  <= data_in_d;
         bus_err_q  <= bus_err_d;
      end
   end

   assign ch_addr     = ch_addr_q;
   assign ch_wdata    = ch_wdata_q;
   assign ch_ren      = ch_ren_q;
   assign ch_wen      = ch_wen_q;
   assign cpu.data_in = data_in_q;
   assign cpu.bus_err = bus_err_q;
endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Scoreboard bench for cpu_bus_ctrl: expected bus values queued at request, checked at completion.
module tb_cpu_bus_ctrl;
   localparam int unsigned NUM_CH = 4;
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned WAIT_W = 3;

   // ch0 0x0000-0x1FFF, ch1 0x0000-0x3FFF (overlaps ch0), ch2 0x4000-0x5FFF, ch3 0x8000-0x9FFF
   localparam logic [NUM_CH*ADDR_W-1:0] BASE = {16'h8000, 16'h4000, 16'h0000, 16'h0000};
   localparam logic [NUM_CH*ADDR_W-1:0] MASK = {16'hE000, 16'hE000, 16'hC000, 16'hE000};
   localparam logic [NUM_CH*WAIT_W-1:0] WAITS = {3'd0, 3'd3, 3'd2, 3'd0};
   localparam logic [NUM_CH-1:0]        ACKS  = 4'b1000;

   logic clk = 1'b0;
   logic rst;
   logic [ADDR_W-1:0]        ch_addr;
   logic [DATA_W-1:0]        ch_wdata;
   logic [NUM_CH-1:0]        ch_ren, ch_wen;
   logic [NUM_CH*DATA_W-1:0] ch_rdata;
   logic [NUM_CH-1:0]        ch_ack;
   int                       ack_cnt = 0;

   int n_vec = 0;
   int n_err = 0;
   logic [DATA_W-1:0] exp_q[$];

   cpu_bus_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cpu_if ();

   cpu_bus_ctrl #(
      .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_W(WAIT_W),
      .CH_BASE(BASE), .CH_MASK(MASK), .CH_WAIT(WAITS), .CH_ACK(ACKS)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cpu      (cpu_if),
      .ch_addr  (ch_addr),
      .ch_wdata (ch_wdata),
      .ch_ren   (ch_ren),
      .ch_wen   (ch_wen),
      .ch_rdata (ch_rdata),
      .ch_ack   (ch_ack)
   );

   always #5 clk = ~clk;

   assign ch_rdata = {8'h77, 8'hA5, 8'h3C, 8'h5A};

   // Target 3 acks on the fifth cycle after its strobe first appears.
   always @(posedge clk) begin
      if (ch_ren[3] || ch_wen[3]) ack_cnt <= ack_cnt + 1;
      else                        ack_cnt <= 0;
   end
   assign ch_ack = {(ch_ren[3] || ch_wen[3]) && (ack_cnt == 5), 3'b000};

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic pop_check(input string tag);
      logic [DATA_W-1:0] e;
      if (exp_q.size() == 0) begin
         check_val({tag, "_qempty"}, 32'(1), 32'(0));
      end else begin
         e = exp_q.pop_front();
         check_val(tag, 32'(cpu_if.data_in), 32'(e));
      end
   endtask

   // One CPU request; exp_ch<0 means unmapped, exp_stall = expected rdy-low cycles.
   task automatic cpu_req(input string tag, input logic [15:0] a, input logic [7:0] d,
                          input logic r, input logic w, input logic [7:0] exp_data,
                          input int exp_ch, input int exp_stall, input logic exp_err);
      logic [7:0] exp_strb;
      int stall;
      exp_strb = 8'h00;
      if (exp_ch >= 0) begin
         if (w) exp_strb = 8'(8'h10 << exp_ch);
         else   exp_strb = 8'(8'h01 << exp_ch);
      end
      @(negedge clk);
      cpu_if.syn_clk  = 1'b1;
      cpu_if.addr_out = a;
      cpu_if.data_out = d;
      cpu_if.ren      = r;
      cpu_if.wen      = w;
      exp_q.push_back(exp_data);
      @(posedge clk);
      #1;
      cpu_if.syn_clk = 1'b0;
      cpu_if.ren     = 1'b0;
      cpu_if.wen     = 1'b0;
      @(negedge clk);
      check_val({tag, "_strb"}, 32'({ch_wen, ch_ren}), 32'(exp_strb));
      check_val({tag, "_err"}, 32'(cpu_if.bus_err), 32'(exp_err));
      if (exp_ch < 0) begin
         check_val({tag, "_rdy"}, 32'(cpu_if.rdy), 32'(1));
         pop_check({tag, "_data"});
      end else begin
         check_val({tag, "_addr"}, 32'(ch_addr), 32'(a));
         stall = 0;
         while (cpu_if.rdy !== 1'b1 && stall <= 20) begin
            stall++;
            @(negedge clk);
            check_val({tag, "_hold"}, 32'({ch_wen, ch_ren}), 32'(exp_strb));
         end
         check_val({tag, "_stall"}, 32'(stall), 32'(exp_stall));
         @(negedge clk);
         pop_check({tag, "_data"});
         check_val({tag, "_idle"}, 32'({ch_wen, ch_ren}), 32'(0));
         check_val({tag, "_rdy1"}, 32'(cpu_if.rdy), 32'(1));
         check_val({tag, "_err0"}, 32'(cpu_if.bus_err), 32'(0));
      end
   endtask

   initial begin
      rst             = 1'b0;
      cpu_if.syn_clk  = 1'b0;
      cpu_if.addr_out = '0;
      cpu_if.data_out = '0;
      cpu_if.ren      = 1'b0;
      cpu_if.wen      = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_strb", 32'({ch_wen, ch_ren}), 32'(0));
      check_val("rst_rdy", 32'(cpu_if.rdy), 32'(1));
      check_val("rst_data", 32'(cpu_if.data_in), 32'(0));
      check_val("rst_err", 32'(cpu_if.bus_err), 32'(0));
      check_val("rst_addr", 32'(ch_addr), 32'(0));
      rst = 1'b1;

      // Set a nonzero bus value, then reset in the middle of a ch1 access.
      cpu_req("uw_ee", 16'hC100, 8'hEE, 1'b0, 1'b1, 8'hEE, -1, 0, 1'b0);
      @(negedge clk);
      cpu_if.syn_clk = 1'b1; cpu_if.addr_out = 16'h2000; cpu_if.ren = 1'b1;
      @(posedge clk);
      #1;
      cpu_if.syn_clk = 1'b0; cpu_if.ren = 1'b0;
      @(negedge clk);
      check_val("mid_strb", 32'(ch_ren), 32'(4'b0010));
      check_val("mid_rdy", 32'(cpu_if.rdy), 32'(0));
      rst = 1'b0;
      @(negedge clk);
      check_val("mrst_strb", 32'({ch_wen, ch_ren}), 32'(0));
      check_val("mrst_rdy", 32'(cpu_if.rdy), 32'(1));
      check_val("mrst_data", 32'(cpu_if.data_in), 32'(0));
      check_val("mrst_err", 32'(cpu_if.bus_err), 32'(0));
      repeat (2) @(negedge clk);
      rst = 1'b1;

      cpu_req("zw_rd",   16'h0123, 8'h00, 1'b1, 1'b0, 8'h5A, 0, 0, 1'b0);
      cpu_req("openbus", 16'hC000, 8'h00, 1'b1, 1'b0, 8'h5A, -1, 0, 1'b0);
      cpu_req("wait_wr", 16'h4010, 8'h55, 1'b0, 1'b1, 8'h55, 2, 3, 1'b0);
      cpu_req("ack_rd",  16'h8004, 8'h00, 1'b1, 1'b0, 8'h77, 3, 5, 1'b0);
      cpu_req("ovl_ch0", 16'h0100, 8'h00, 1'b1, 1'b0, 8'h5A, 0, 0, 1'b0);
      cpu_req("ch1_rd",  16'h2100, 8'h00, 1'b1, 1'b0, 8'h3C, 1, 2, 1'b0);
      cpu_req("illegal", 16'h0200, 8'h99, 1'b1, 1'b1, 8'h99, 0, 0, 1'b1);
      cpu_req("u_ill",   16'hE000, 8'h12, 1'b1, 1'b1, 8'h12, -1, 0, 1'b1);
      @(negedge clk);
      check_val("u_ill_err0", 32'(cpu_if.bus_err), 32'(0));

      // Request with syn_clk low must be ignored.
      cpu_if.addr_out = 16'h0010; cpu_if.ren = 1'b1;
      @(posedge clk);
      #1;
      cpu_if.ren = 1'b0;
      @(negedge clk);
      check_val("nosyn_strb", 32'({ch_wen, ch_ren}), 32'(0));
      check_val("nosyn_data", 32'(cpu_if.data_in), 32'(8'h12));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=0x0 exp=0x1");
      $fatal(1, "timeout");
   end
endmodule
